// File: rtl/basilisk_memory_responder.sv
// basilisk_memory_responder
// Executes basilisk memory commands: forms the word address, drives a
// valid/ready memory request port, remembers the destination of every
// outstanding load in issue order and turns load data into register-file
// writeback beats. Stores finish once the memory port takes the request.

module basilisk_memory_responder #(
   parameter int MAX_OUTSTANDING = 4,   // power of 2, >= 2
   parameter int OFFSET_WIDTH    = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,

   // command stream from basilisk issue
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [4:0]              cmd_dest_reg,
   input  logic [OFFSET_WIDTH-1:0] cmd_dest_offset,
   input  logic                    cmd_op,          // 0 = load, 1 = store
   input  logic [31:0]             cmd_a,
   input  logic [31:0]             cmd_base,
   input  logic [31:0]             cmd_offset,

   // data-memory request port
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic                    mem_req_write,
   output logic [31:0]             mem_req_addr,
   output logic [31:0]             mem_req_wdata,

   // data-memory response port (in request order)
   input  logic                    mem_resp_valid,
   output logic                    mem_resp_ready,
   input  logic [31:0]             mem_resp_data,

   // FP register-file writeback
   output logic                    wb_valid,
   input  logic                    wb_ready,
   output logic [4:0]              wb_dest_reg,
   output logic [OFFSET_WIDTH-1:0] wb_dest_offset,
   output logic [31:0]             wb_result,

   output logic                    error_unexpected
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   localparam logic CMD_STORE = 1'b1;

   // destination of one outstanding load
   typedef struct packed {
      logic [4:0]              dest_reg;
      logic [OFFSET_WIDTH-1:0] dest_offset;
   } tag_t;

   tag_t             tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] load_count;

   logic [31:0]      addr_sum;
   logic             cmd_accept;
   logic             load_accept;
   logic             resp_capture;
   logic             tag_pop;

   // Loads reserve a tag slot when the command is accepted, so a full FIFO
   // refuses loads even if a response frees a slot in the same cycle.
   assign cmd_ready    = (!mem_req_valid || mem_req_ready)
                      && (cmd_op == CMD_STORE || load_count < CNT_MAX);
   assign cmd_accept   = cmd_valid && cmd_ready;
   assign load_accept  = cmd_accept && (cmd_op != CMD_STORE);

   assign addr_sum     = cmd_base + cmd_offset;

   assign mem_resp_ready = !wb_valid || wb_ready;
   assign resp_capture   = mem_resp_valid && mem_resp_ready;
   assign tag_pop        = resp_capture && (load_count != '0);

   // Request register: load on accept, hold while the memory stalls.
   // NOTE: registers are written with <= so every flop samples the
   // pre-edge values; blocking assignments here would create ordering bugs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
      end else if (cmd_accept) begin
         mem_req_valid <= 1'b1;
         mem_req_write <= cmd_op;
         mem_req_addr  <= addr_sum & 32'hFFFF_FFFC;
         mem_req_wdata <= (cmd_op == CMD_STORE) ? cmd_a : '0;
      end else if (mem_req_ready) begin
         mem_req_valid <= 1'b0;
      end
   end

   // Tag storage: written at the write pointer on every accepted load.
   // NOTE: the storage array has no reset; load_count alone says which
   // entries are live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (load_accept) begin
         tag_mem[wr_ptr] <= '{dest_reg: cmd_dest_reg, dest_offset: cmd_dest_offset};
      end
   end

   // Tag FIFO pointers and outstanding-load count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         load_count <= '0;
      end else begin
         if (load_accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (tag_pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({load_accept, tag_pop})
            2'b10:   load_count <= load_count + CNT_W'(1);
            2'b01:   load_count <= load_count - CNT_W'(1);
            default: load_count <= load_count;
         endcase
      end
   end

   // Writeback register: filled from the oldest tag plus response data,
   // held until the register file takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid       <= 1'b0;
         wb_dest_reg    <= '0;
         wb_dest_offset <= '0;
         wb_result      <= '0;
      end else if (tag_pop) begin
         wb_valid       <= 1'b1;
         wb_dest_reg    <= tag_mem[rd_ptr].dest_reg;
         wb_dest_offset <= tag_mem[rd_ptr].dest_offset;
         wb_result      <= mem_resp_data;
      end else if (wb_ready) begin
         wb_valid       <= 1'b0;
      end
   end

   // Sticky flag for a response that no load was waiting for.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_unexpected <= 1'b0;
      end else if (resp_capture && load_count == '0) begin
         error_unexpected <= 1'b1;
      end
   end

endmodule

// File: tb/tb_basilisk_memory_responder.sv
// Testbench for basilisk_memory_responder: directed stimulus with a
// queue-based scoreboard. A producer process records expected memory
// requests and writebacks at each input handshake; a separate monitor pops
// and compares whenever the DUT completes an output handshake.

module tb_basilisk_memory_responder;

   localparam int MAXO = 4;
   localparam int OW   = 1;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [4:0]    cmd_dest_reg;
   logic [OW-1:0] cmd_dest_offset;
   logic          cmd_op;
   logic [31:0]   cmd_a;
   logic [31:0]   cmd_base;
   logic [31:0]   cmd_offset;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_write;
   logic [31:0]   mem_req_addr;
   logic [31:0]   mem_req_wdata;
   logic          mem_resp_valid;
   logic          mem_resp_ready;
   logic [31:0]   mem_resp_data;
   logic          wb_valid;
   logic          wb_ready;
   logic [4:0]    wb_dest_reg;
   logic [OW-1:0] wb_dest_offset;
   logic [31:0]   wb_result;
   logic          error_unexpected;

   basilisk_memory_responder #(
      .MAX_OUTSTANDING (MAXO),
      .OFFSET_WIDTH    (OW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_dest_reg     (cmd_dest_reg),
      .cmd_dest_offset  (cmd_dest_offset),
      .cmd_op           (cmd_op),
      .cmd_a            (cmd_a),
      .cmd_base         (cmd_base),
      .cmd_offset       (cmd_offset),
      .mem_req_valid    (mem_req_valid),
      .mem_req_ready    (mem_req_ready),
      .mem_req_write    (mem_req_write),
      .mem_req_addr     (mem_req_addr),
      .mem_req_wdata    (mem_req_wdata),
      .mem_resp_valid   (mem_resp_valid),
      .mem_resp_ready   (mem_resp_ready),
      .mem_resp_data    (mem_resp_data),
      .wb_valid         (wb_valid),
      .wb_ready         (wb_ready),
      .wb_dest_reg      (wb_dest_reg),
      .wb_dest_offset   (wb_dest_offset),
      .wb_result        (wb_result),
      .error_unexpected (error_unexpected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [4:0]    dreg;
      logic [OW-1:0] doff;
   } tag_t;

   typedef struct {
      logic [4:0]    dreg;
      logic [OW-1:0] doff;
      logic [31:0]   data;
   } wb_t;

   req_t exp_req_q[$];
   tag_t pend_q[$];
   wb_t  exp_wb_q[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_model();
      exp_req_q.delete();
      pend_q.delete();
      exp_wb_q.delete();
   endtask

   // Present one command and hold it until accepted (bounded).
   task automatic issue(input logic op, input logic [4:0] dreg, input logic [OW-1:0] doff,
                        input logic [31:0] a, input logic [31:0] base, input logic [31:0] off);
      int n = 0;
      cmd_valid       = 1'b1;
      cmd_op          = op;
      cmd_dest_reg    = dreg;
      cmd_dest_offset = doff;
      cmd_a           = a;
      cmd_base        = base;
      cmd_offset      = off;
      #1;
      while (!cmd_ready && n < 50) begin
         step();
         n++;
      end
      if (!cmd_ready) begin
         tests++;
         fails++;
         $display("FAIL issue_timeout: cmd_ready stayed 0, expected 1 within 50 cycles");
      end
      step();
      cmd_valid = 1'b0;
   endtask

   // Present one memory response and hold it until captured (bounded).
   task automatic send_resp(input logic [31:0] d);
      int n = 0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = d;
      #1;
      while (!mem_resp_ready && n < 50) begin
         step();
         n++;
      end
      if (!mem_resp_ready) begin
         tests++;
         fails++;
         $display("FAIL resp_timeout: mem_resp_ready stayed 0, expected 1 within 50 cycles");
      end
      step();
      mem_resp_valid = 1'b0;
   endtask

   // Producer: record expectations at each input-side handshake.
   always @(negedge clk) begin : producer
      req_t r;
      tag_t t;
      wb_t  w;
      if (rst_n) begin
         if (cmd_valid && cmd_ready) begin
            r.write = cmd_op;
            r.addr  = (cmd_base + cmd_offset) & 32'hFFFF_FFFC;
            r.wdata = cmd_a;
            exp_req_q.push_back(r);
            if (!cmd_op) begin
               t.dreg = cmd_dest_reg;
               t.doff = cmd_dest_offset;
               pend_q.push_back(t);
            end
         end
         if (mem_resp_valid && mem_resp_ready && pend_q.size() > 0) begin
            t      = pend_q.pop_front();
            w.dreg = t.dreg;
            w.doff = t.doff;
            w.data = mem_resp_data;
            exp_wb_q.push_back(w);
         end
      end
   end

   // Monitor: compare every output-side handshake against the queues.
   always @(negedge clk) begin : monitor
      req_t r;
      wb_t  w;
      if (rst_n) begin
         if (mem_req_valid && mem_req_ready) begin
            if (exp_req_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL req_unexpected: got request addr 0x%08h, expected none", mem_req_addr);
            end else begin
               r = exp_req_q.pop_front();
               check("req_addr", mem_req_addr, r.addr);
               check("req_write", 32'(mem_req_write), 32'(r.write));
               if (r.write) check("req_wdata", mem_req_wdata, r.wdata);
            end
         end
         if (wb_valid && wb_ready) begin
            if (exp_wb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL wb_unexpected: got wb reg %0d result 0x%08h, expected none",
                        wb_dest_reg, wb_result);
            end else begin
               w = exp_wb_q.pop_front();
               check("wb_reg", 32'(wb_dest_reg), 32'(w.dreg));
               check("wb_offset", 32'(wb_dest_offset), 32'(w.doff));
               check("wb_result", wb_result, w.data);
            end
         end
      end
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      cmd_valid       = 1'b0;
      cmd_dest_reg    = '0;
      cmd_dest_offset = '0;
      cmd_op          = 1'b0;
      cmd_a           = '0;
      cmd_base        = '0;
      cmd_offset      = '0;
      mem_req_ready   = 1'b1;
      mem_resp_valid  = 1'b0;
      mem_resp_data   = '0;
      wb_ready        = 1'b1;

      // ---- reset state ----
      repeat (3) step();
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_error", 32'(error_unexpected), 32'd0);
      check("rst_req_addr", mem_req_addr, 32'd0);
      check("rst_wb_result", wb_result, 32'd0);
      rst_n = 1'b1;
      step();
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      check("idle_resp_ready", 32'(mem_resp_ready), 32'd1);

      // ---- single load ----
      issue(1'b0, 5'd3, 1'b0, 32'h0, 32'h0000_1000, 32'h0000_0008);
      check("load_req_valid_latency", 32'(mem_req_valid), 32'd1);
      check("load_req_addr", mem_req_addr, 32'h0000_1008);
      check("load_req_write", 32'(mem_req_write), 32'd0);
      step();
      step();
      send_resp(32'hDEAD_BEEF);
      check("load_wb_valid", 32'(wb_valid), 32'd1);
      check("load_wb_reg", 32'(wb_dest_reg), 32'd3);
      check("load_wb_result", wb_result, 32'hDEAD_BEEF);
      step();
      check("load_wb_done", 32'(wb_valid), 32'd0);

      // ---- store with a stalled memory port ----
      mem_req_ready = 1'b0;
      issue(1'b1, 5'd0, 1'b0, 32'h1234_5678, 32'h0000_2003, 32'h0000_0001);
      check("store_blocks_cmd", 32'(cmd_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("store_hold_valid", 32'(mem_req_valid), 32'd1);
         check("store_hold_addr", mem_req_addr, 32'h0000_2004);
         check("store_hold_write", 32'(mem_req_write), 32'd1);
         check("store_hold_wdata", mem_req_wdata, 32'h1234_5678);
         step();
      end
      mem_req_ready = 1'b1;
      step();
      check("store_req_done", 32'(mem_req_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("store_no_wb", 32'(wb_valid), 32'd0);
         step();
      end

      // ---- fill the tag FIFO, fifth load waits for a capture ----
      for (int i = 0; i < MAXO; i++) begin
         issue(1'b0, 5'(10 + i), OW'(i), 32'h0, 32'h0000_0100, 32'(i * 4));
      end
      cmd_valid       = 1'b1;
      cmd_op          = 1'b0;
      cmd_dest_reg    = 5'd14;
      cmd_dest_offset = 1'b0;
      cmd_base        = 32'h0000_0100;
      cmd_offset      = 32'h0000_0010;
      #1;
      check("fifth_load_blocked", 32'(cmd_ready), 32'd0);
      step();
      check("fifth_load_still_blocked", 32'(cmd_ready), 32'd0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_00A0;
      #1;
      check("full_resp_ready", 32'(mem_resp_ready), 32'd1);
      step();
      mem_resp_valid = 1'b0;
      check("fifth_load_after_capture", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      send_resp(32'h0000_00A1);
      send_resp(32'h0000_00A2);
      send_resp(32'h0000_00A3);
      send_resp(32'h0000_00A4);
      check("fifth_wb_reg", 32'(wb_dest_reg), 32'd14);
      check("fifth_wb_result", wb_result, 32'h0000_00A4);
      step();

      // ---- writeback back-pressure, in-order completion ----
      issue(1'b0, 5'd2, 1'b1, 32'h0, 32'h0000_0300, 32'h0);
      issue(1'b0, 5'd7, 1'b0, 32'h0, 32'h0000_0304, 32'h0);
      step();
      wb_ready = 1'b0;
      send_resp(32'h2222_0002);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h7777_0007;
      #1;
      for (int i = 0; i < 10; i++) begin
         check("bp_resp_ready", 32'(mem_resp_ready), 32'd0);
         check("bp_wb_valid", 32'(wb_valid), 32'd1);
         check("bp_wb_reg", 32'(wb_dest_reg), 32'd2);
         check("bp_wb_offset", 32'(wb_dest_offset), 32'd1);
         check("bp_wb_result", wb_result, 32'h2222_0002);
         step();
      end
      wb_ready = 1'b1;
      #1;
      check("bp_resp_ready_release", 32'(mem_resp_ready), 32'd1);
      step();
      mem_resp_valid = 1'b0;
      check("bp_second_wb_valid", 32'(wb_valid), 32'd1);
      check("bp_second_wb_reg", 32'(wb_dest_reg), 32'd7);
      check("bp_second_wb_result", wb_result, 32'h7777_0007);
      step();
      check("bp_drained", 32'(wb_valid), 32'd0);

      // ---- unexpected response ----
      send_resp(32'hBAD0_BAD0);
      check("unexp_error_set", 32'(error_unexpected), 32'd1);
      check("unexp_no_wb", 32'(wb_valid), 32'd0);
      repeat (3) step();
      check("unexp_error_sticky", 32'(error_unexpected), 32'd1);
      check("unexp_still_no_wb", 32'(wb_valid), 32'd0);
      rst_n = 1'b0;
      flush_model();
      #2;
      check("unexp_error_cleared", 32'(error_unexpected), 32'd0);
      rst_n = 1'b1;
      step();

      // ---- reset with loads in flight ----
      issue(1'b0, 5'd20, 1'b0, 32'h0, 32'h0000_0500, 32'h0);
      issue(1'b0, 5'd21, 1'b1, 32'h0, 32'h0000_0504, 32'h0);
      issue(1'b0, 5'd22, 1'b0, 32'h0, 32'h0000_0508, 32'h0);
      #1;
      rst_n = 1'b0;
      flush_model();
      #1;
      check("midrst_req_valid", 32'(mem_req_valid), 32'd0);
      check("midrst_req_write", 32'(mem_req_write), 32'd0);
      check("midrst_req_addr", mem_req_addr, 32'd0);
      check("midrst_req_wdata", mem_req_wdata, 32'd0);
      check("midrst_wb_valid", 32'(wb_valid), 32'd0);
      check("midrst_wb_reg", 32'(wb_dest_reg), 32'd0);
      check("midrst_wb_offset", 32'(wb_dest_offset), 32'd0);
      check("midrst_wb_result", wb_result, 32'd0);
      check("midrst_error", 32'(error_unexpected), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      issue(1'b0, 5'd9, 1'b1, 32'h0, 32'h0000_0040, 32'h0000_0004);
      check("post_rst_req_addr", mem_req_addr, 32'h0000_0044);
      step();
      send_resp(32'hCAFE_F00D);
      check("post_rst_wb_valid", 32'(wb_valid), 32'd1);
      check("post_rst_wb_reg", 32'(wb_dest_reg), 32'd9);
      check("post_rst_wb_offset", 32'(wb_dest_offset), 32'd1);
      check("post_rst_wb_result", wb_result, 32'hCAFE_F00D);
      check("post_rst_no_error", 32'(error_unexpected), 32'd0);
      repeat (3) step();

      // ---- every expectation consumed ----
      check("sb_req_drained", 32'(exp_req_q.size()), 32'd0);
      check("sb_tag_drained", 32'(pend_q.size()), 32'd0);
      check("sb_wb_drained", 32'(exp_wb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
